// File: rtl/nn_feeder_if.sv
// Bundle of operand-load, stream, result and status signals between a host/neuron and nn_feeder.
// The slave modport is the feeder side; the master modport is the host and neuron side.
interface nn_feeder_if #(
   parameter int N_MAX = 16
);
   localparam int AW = $clog2(N_MAX);

   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_x;
   logic [31:0]   ld_w;
   logic          start;
   logic [AW:0]   len;
   logic [31:0]   x;
   logic [31:0]   w;
   logic          x_v;
   logic          w_v;
   logic          x_l;
   logic [31:0]   y;
   logic          y_v;
   logic [31:0]   result;
   logic          done;
   logic          busy;
   logic          err;

   modport master (
      output ld_en, ld_addr, ld_x, ld_w, start, len, y, y_v,
      input  x, w, x_v, w_v, x_l, result, done, busy, err
   );

   modport slave (
      input  ld_en, ld_addr, ld_x, ld_w, start, len, y, y_v,
      output x, w, x_v, w_v, x_l, result, done, busy, err
   );
endinterface

// File: rtl/nn_feeder.sv
// Streams a stored (x, w) vector to a neuron with no backpressure, then waits for its result.
//   state    | meaning
//   S_IDLE   | store writable, waiting for start
//   S_STREAM | one (x, w) beat per cycle, idx = 0..len-1
//   S_WAIT   | beats done, waiting up to TIMEOUT cycles for y_v
//   S_DONE   | one-cycle done pulse, then back to S_IDLE
module nn_feeder #(
   parameter int N_MAX   = 16,
   parameter int TIMEOUT = 255
) (
   input logic        clk,
   input logic        rst,
   nn_feeder_if.slave bus
);
   localparam int AW = $clog2(N_MAX);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] ZERO_IDX = '0;

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [31:0]   r_mem_x [N_MAX];
   logic [31:0]   r_mem_w [N_MAX];
   logic [AW-1:0] r_idx;
   logic [AW:0]   r_len;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_x;
   logic [31:0]   r_w;
   logic [31:0]   r_result;
   logic          r_xv;
   logic          r_xl;
   logic          r_err;

   logic          w_len_ok;
   logic          w_last;
   logic          w_tmo;

   assign w_len_ok = (bus.len != '0) && (bus.len <= (AW+1)'(N_MAX));
   assign w_last   = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
   assign w_tmo    = (r_cnt == CW'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (bus.start) w_next = w_len_ok ? S_STREAM : S_DONE;
         S_STREAM: if (w_last) w_next = S_WAIT;
         S_WAIT:   if (bus.y_v || w_tmo) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Operand store has no reset; contents are undefined until loaded.
   always_ff @(posedge clk) begin
      if (bus.ld_en && (r_state == S_IDLE)) begin
         r_mem_x[bus.ld_addr] <= bus.ld_x;
         r_mem_w[bus.ld_addr] <= bus.ld_w;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx    <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_x      <= '0;
         r_w      <= '0;
         r_result <= '0;
         r_xv     <= 1'b0;
         r_xl     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start && w_len_ok) begin
                  // Beat 0 is registered on the accepting edge so it shows up the next cycle.
                  r_len <= bus.len;
                  r_idx <= '0;
                  r_err <= 1'b0;
                  r_x   <= r_mem_x[ZERO_IDX];
                  r_w   <= r_mem_w[ZERO_IDX];
                  r_xv  <= 1'b1;
                  r_xl  <= (bus.len == (AW+1)'(1));
               end else if (bus.start) begin
                  r_err <= 1'b1;
               end
            end
            S_STREAM: begin
               if (w_last) begin
                  r_xv  <= 1'b0;
                  r_xl  <= 1'b0;
                  r_cnt <= '0;
               end else begin
                  r_idx <= r_idx + AW'(1);
                  r_x   <= r_mem_x[r_idx + AW'(1)];
                  r_w   <= r_mem_w[r_idx + AW'(1)];
                  r_xl  <= (({1'b0, r_idx} + (AW+1)'(2)) == r_len);
               end
            end
            S_WAIT: begin
               if (bus.y_v)  r_result <= bus.y;
               else if (w_tmo) r_err  <= 1'b1;
               else          r_cnt    <= r_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.x      = r_x;
   assign bus.w      = r_w;
   assign bus.x_v    = r_xv;
   assign bus.w_v    = r_xv;
   assign bus.x_l    = r_xl;
   assign bus.result = r_result;
   assign bus.err    = r_err;
   assign bus.done   = (r_state == S_DONE);
   assign bus.busy   = (r_state != S_IDLE);
endmodule
